neuron_mac_core: RTL and testbench

- Downstream consumer of the test-vector generator's DATA_BUS / wr_en / chip_sel stream.
- Receives one frame of N_INPUTS packed input/weight words, then two threshold words.
- Accumulates signed 8x8 products through a 2-stage pipeline and compares the sum against a signed 32-bit threshold.
- Returns neuron_out and asserts output_ready until chip_sel drops.

---
 rtl/neuron_mac_core.sv | 143 ++++++++++++++
 tb/tb_neuron_mac_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_core.sv
// neuron_mac_core: frame-based signed 8x8 MAC neuron with a signed 32-bit threshold compare.
// Define NEURON_SAT_EN for saturating accumulation and the extra sat_flag output.
module neuron_mac_core #(
  parameter int N_INPUTS  = 64,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chip_sel,
  input  logic                 wr_en,
  input  logic [15:0]          DATA_BUS,
  output logic                 output_ready,
  output logic                 neuron_out,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 frame_err,
`ifdef NEURON_SAT_EN
  output logic                 sat_flag,
`endif
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, LOAD, THRESH, COMPARE, DONE} state_t;
  localparam int CW = $clog2(N_INPUTS + 3);

  state_t                       state, state_nx;
  logic [CW-1:0]                cnt;
  logic signed [15:0]           prod;
  logic                         p_vld;
  logic signed [ACC_WIDTH-1:0]  acc, acc_nx, prod_ext;
  logic signed [31:0]           thr;
  logic                         accept, abort, last_in;

  assign accept   = chip_sel & wr_en;
  assign abort    = !chip_sel && (state == LOAD || state == THRESH || state == COMPARE);
  assign last_in  = accept && (cnt == CW'(N_INPUTS - 1));
  assign prod_ext = ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  // THRESH lingers one cycle after the high half (cnt==2) so compare sees a settled threshold
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (chip_sel) state_nx = last_in ? THRESH : LOAD;
      LOAD:    if (!chip_sel) state_nx = IDLE; else if (last_in) state_nx = THRESH;
      THRESH:  if (!chip_sel) state_nx = IDLE; else if (cnt == CW'(2)) state_nx = COMPARE;
      COMPARE: state_nx = chip_sel ? DONE : IDLE;
      DONE:    if (!chip_sel) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      thr <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE, LOAD:
          if (accept) cnt <= last_in ? '0 : cnt + CW'(1);
        THRESH:
          if (accept && cnt != CW'(2)) begin
            if (cnt == '0) thr[15:0]  <= DATA_BUS;
            else           thr[31:16] <= DATA_BUS;
            cnt <= cnt + CW'(1);
          end
        default: cnt <= '0;
      endcase
    end

  // stage 1: registered product
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prod  <= '0;
      p_vld <= 1'b0;
    end else begin
      prod  <= 16'($signed(DATA_BUS[15:8])) * 16'($signed(DATA_BUS[7:0]));
      p_vld <= accept && (state == IDLE || state == LOAD);
    end

`ifdef NEURON_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        ovf, sat_run;

  // overflow only when both operands share a sign and the sum flips it
  always_comb begin
    sum    = acc + prod_ext;
    ovf    = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    acc_nx = ovf ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset)                       sat_run <= 1'b0;
    else if (state == IDLE || abort)  sat_run <= 1'b0;
    else if (p_vld && ovf)            sat_run <= 1'b1;
`else
  assign acc_nx = acc + prod_ext;
`endif

  // stage 2: accumulate
  always_ff @(posedge clk or negedge reset)
    if (!reset)                       acc <= '0;
    else if (state == IDLE || abort)  acc <= '0;
    else if (p_vld)                   acc <= acc_nx;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      output_ready <= 1'b0;
      neuron_out   <= 1'b0;
      acc_out      <= '0;
      frame_err    <= 1'b0;
`ifdef NEURON_SAT_EN
      sat_flag     <= 1'b0;
`endif
    end else begin
      frame_err <= abort;
      if (state == COMPARE && chip_sel) begin
        output_ready <= 1'b1;
        neuron_out   <= (32'(acc) >= thr);
        acc_out      <= acc;
`ifdef NEURON_SAT_EN
        sat_flag     <= sat_run;
`endif
      end else if (state == DONE && !chip_sel) begin
        output_ready <= 1'b0;
        neuron_out   <= 1'b0;
`ifdef NEURON_SAT_EN
        sat_flag     <= 1'b0;
`endif
      end
    end

endmodule

// File: tb/tb_neuron_mac_core.sv
// Bench for neuron_mac_core: two instances (ACC_WIDTH 24 and 17) checked every cycle
// against a frame-level arithmetic model, plus hand-computed literal expectations.
module tb_neuron_mac_core;
  localparam int N = 64;
  localparam int W0 = 24;
  localparam int W1 = 17;

  logic clk = 1'b0, reset = 1'b1, chip_sel = 1'b0, wr_en = 1'b0;
  logic [15:0] DATA_BUS = '0;
  logic output_ready, neuron_out, frame_err, busy;
  logic output_ready17, neuron_out17, frame_err17, busy17;
  logic [W0-1:0] acc_out;
  logic [W1-1:0] acc_out17;
`ifdef NEURON_SAT_EN
  logic sat_flag, sat_flag17;
`endif

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  neuron_mac_core #(.N_INPUTS(N), .ACC_WIDTH(W0)) u_dut (
    .clk(clk), .reset(reset), .chip_sel(chip_sel), .wr_en(wr_en), .DATA_BUS(DATA_BUS),
    .output_ready(output_ready), .neuron_out(neuron_out), .acc_out(acc_out),
    .frame_err(frame_err),
`ifdef NEURON_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy));

  neuron_mac_core #(.N_INPUTS(N), .ACC_WIDTH(W1)) u_dut17 (
    .clk(clk), .reset(reset), .chip_sel(chip_sel), .wr_en(wr_en), .DATA_BUS(DATA_BUS),
    .output_ready(output_ready17), .neuron_out(neuron_out17), .acc_out(acc_out17),
    .frame_err(frame_err17),
`ifdef NEURON_SAT_EN
    .sat_flag(sat_flag17),
`endif
    .busy(busy17));

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic   m_busy, m_ready, m_err;
  int     m_words, m_wait;
  longint raw [2];
  logic   srun [2];
  longint m_acc [2];
  logic   m_nout [2];
  logic   m_sat [2];
  logic [31:0] m_thr;

  function automatic longint wrapw(input longint v, input int w);
    longint one, m;
    one = 1;
    m = v & ((one << w) - 1);
    if (m >= (one << (w - 1))) m -= (one << w);
    return m;
  endfunction

  function automatic longint add_p(input longint a, input longint p, input int w, output logic s);
    longint r, lim;
    r = a + p;
    s = 1'b0;
`ifdef NEURON_SAT_EN
    lim = longint'(1) << (w - 1);
    if (r > lim - 1) begin r = lim - 1; s = 1'b1; end
    if (r < -lim)    begin r = -lim;    s = 1'b1; end
`else
    lim = w;
`endif
    return r;
  endfunction

  task automatic m_clear();
    m_busy = 0; m_ready = 0; m_err = 0; m_words = 0; m_wait = 0; m_thr = '0;
    for (int k = 0; k < 2; k++) begin
      raw[k] = 0; srun[k] = 0; m_acc[k] = 0; m_nout[k] = 0; m_sat[k] = 0;
    end
  endtask

  task automatic m_take(input logic [15:0] d);
    longint p;
    logic s;
    if (m_words < N) begin
      p = longint'($signed(d[15:8])) * longint'($signed(d[7:0]));
      raw[0] = add_p(raw[0], p, W0, s); srun[0] |= s;
      raw[1] = add_p(raw[1], p, W1, s); srun[1] |= s;
    end else if (m_words == N) m_thr[15:0]  = d;
    else                       m_thr[31:16] = d;
    m_words++;
  endtask

  task automatic m_step();
    m_err = 0;
    if (!m_busy) begin
      raw[0] = 0; raw[1] = 0; srun[0] = 0; srun[1] = 0;
      if (chip_sel) begin
        m_busy = 1; m_words = 0; m_wait = 0;
        if (wr_en) m_take(DATA_BUS);
      end
    end else if (m_ready) begin
      if (!chip_sel) begin m_busy = 0; m_ready = 0; m_nout[0] = 0; m_nout[1] = 0; end
    end else if (!chip_sel) begin
      m_busy = 0; m_err = 1;
    end else if (m_words == N + 2) begin
      m_wait++;
      if (m_wait == 2) begin
        m_acc[0] = wrapw(raw[0], W0);
        m_acc[1] = wrapw(raw[1], W1);
        for (int k = 0; k < 2; k++) begin
          m_nout[k] = (m_acc[k] >= longint'($signed(m_thr)));
          m_sat[k]  = srun[k];
        end
        m_ready = 1;
      end
    end else if (wr_en) m_take(DATA_BUS);
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk);
      if (!reset) m_clear();
      else        m_step();
    end
  end

  // per-cycle compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("ready",   output_ready,   m_ready);
      chk("ready17", output_ready17, m_ready);
      chk("busy",    busy,           m_busy);
      chk("busy17",  busy17,         m_busy);
      chk("err",     frame_err,      m_err);
      chk("err17",   frame_err17,    m_err);
      chk("nout",    neuron_out,     m_nout[0]);
      chk("nout17",  neuron_out17,   m_nout[1]);
      chk("acc",     longint'($signed(acc_out)),   m_acc[0]);
      chk("acc17",   longint'($signed(acc_out17)), m_acc[1]);
`ifdef NEURON_SAT_EN
      chk("sat",     sat_flag,   m_ready ? m_sat[0] : 1'b0);
      chk("sat17",   sat_flag17, m_ready ? m_sat[1] : 1'b0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input logic [15:0] dw, input bit rnd, input logic [15:0] tl,
                           input logic [15:0] th, input int gap, output int lat,
                           output longint a0, output longint a1, output logic n0, output logic n1);
    int g;
    @(negedge clk);
    chip_sel = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      wr_en = 1'b1;
      DATA_BUS = (i < N) ? (rnd ? 16'($urandom) : dw) : ((i == N) ? tl : th);
      @(negedge clk);
      wr_en = 1'b0;
      DATA_BUS = 16'($urandom);
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      if (i < N + 1) repeat (g) @(negedge clk);
    end
    lat = 1;
    while (!output_ready && lat < 10) begin @(negedge clk); lat++; end
    a0 = $signed(acc_out);
    a1 = $signed(acc_out17);
    n0 = neuron_out;
    n1 = neuron_out17;
    wr_en = 1'b1;
    DATA_BUS = 16'($urandom);
    repeat (2) @(negedge clk);
    chip_sel = 1'b0;
    repeat (2) @(negedge clk);
    wr_en = 1'b0;
  endtask

  int lat;
  longint a0, a1;
  logic n0, n1;

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ready", output_ready, 0);
    chk("rst busy",  busy, 0);
    chk("rst acc",   acc_out, 0);
    #2 reset = 1'b1;

    run_frame(16'h0101, 0, 16'h0040, 16'h0000, 0, lat, a0, a1, n0, n1);
    chk("lit latency", lat, 3);
    chk("lit 1x1 acc", a0, 64);
    chk("lit 1x1 nout", n0, 1);
    chk("lit 1x1 acc17", a1, 64);

    run_frame(16'h0101, 0, 16'h0041, 16'h0000, 0, lat, a0, a1, n0, n1);
    chk("lit thr65 acc", a0, 64);
    chk("lit thr65 nout", n0, 0);

    for (int sp = 0; sp <= 3; sp += 3) begin
      run_frame(16'h8080, 0, 16'h0000, 16'h0010, sp, lat, a0, a1, n0, n1);
      chk("lit 8080 acc", a0, 64'h100000);
      chk("lit 8080 nout", n0, 1);
`ifdef NEURON_SAT_EN
      chk("lit 8080 acc17 sat", a1, 65535);
`else
      chk("lit 8080 acc17 wrap", a1, 0);
`endif
      chk("lit 8080 nout17", n1, 0);
    end

    run_frame(16'h02FD, 0, 16'hFE80, 16'hFFFF, 1, lat, a0, a1, n0, n1);
    chk("lit neg acc", a0, -384);
    chk("lit neg nout", n0, 1);
    run_frame(16'h02FD, 0, 16'hFE81, 16'hFFFF, 0, lat, a0, a1, n0, n1);
    chk("lit neg nout2", n0, 0);

    // abort after word 10
    @(negedge clk);
    chip_sel = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wr_en = 1'b1; DATA_BUS = 16'h7F7F;
      @(negedge clk);
    end
    wr_en = 1'b0;
    chip_sel = 1'b0;
    @(negedge clk);
    chk("lit abort err", frame_err, 1);
    chk("lit abort ready", output_ready, 0);
    @(negedge clk);
    chk("lit abort err clr", frame_err, 0);
    run_frame(16'h0101, 0, 16'h0040, 16'h0000, 0, lat, a0, a1, n0, n1);
    chk("lit post-abort acc", a0, 64);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    chip_sel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; DATA_BUS = 16'($urandom);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1 chk("lit async rst busy", busy, 0);
    chip_sel = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;

    for (int f = 0; f < 20; f++)
      run_frame(16'h0000, 1, 16'($urandom), ($urandom_range(1, 0) != 0) ? 16'hFFFF : 16'h0000,
                -1, lat, a0, a1, n0, n1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
